// File: rtl/alarm_sensor_pio_pkg.sv
// rtl/alarm_sensor_pio_pkg.sv - register map, edge-mode encodings and edge-select helper
package alarm_pio_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_RSVD    = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    // cur is the debounced level, dly the same level one clock earlier
    function automatic logic edge_hit(input int mode, input logic cur, input logic dly);
        case (mode)
            EDGE_FALL: return !cur && dly;
            EDGE_ANY:  return cur != dly;
            default:   return cur && !dly;
        endcase
    endfunction

endpackage

// File: rtl/alarm_sensor_pio_if.sv
// rtl/alarm_sensor_pio_if.sv - Avalon-MM register port plus interrupt line
interface alarm_sensor_pio_if;

    logic [1:0]  address;
    logic        chipselect;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (
        output address, chipselect, write, writedata,
        input  readdata, irq
    );

    modport slave (
        input  address, chipselect, write, writedata,
        output readdata, irq
    );

endinterface

// File: rtl/alarm_sensor_pio_debounce.sv
// rtl/alarm_sensor_pio_debounce.sv - single-bit debouncer on an already synchronised input
module alarm_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sync_in,
    output logic deb_out
);

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) deb_out <= 1'b0;
                else          deb_out <= sync_in;
            end
        end else begin : g_count
            localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
            localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

            logic [CW-1:0] cnt;

            // Counter tops out at CNT_MAX, where the new level is accepted
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    cnt     <= '0;
                    deb_out <= 1'b0;
                end else if (sync_in == deb_out) begin
                    cnt <= '0;
                end else if (cnt == CNT_MAX) begin
                    cnt     <= '0;
                    deb_out <= sync_in;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    endgenerate

endmodule

// File: rtl/alarm_sensor_pio.sv
// rtl/alarm_sensor_pio.sv - debounced sensor PIO with edge capture and masked level irq
module alarm_sensor_pio
    import alarm_pio_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int EDGE_MODE       = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_port,
    alarm_sensor_pio_if.slave bus
);

    logic [WIDTH-1:0] sync1, sync2;
    logic [WIDTH-1:0] deb, deb_dly;
    logic [WIDTH-1:0] edge_vec, clr_vec;
    logic [WIDTH-1:0] irqmask, edgecap;
    logic [31:0]      rd_next;
    logic             wr_en;
    logic             unused_wdata;

    assign unused_wdata = ^bus.writedata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= in_port;
            sync2 <= sync1;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_deb
        alarm_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
            .clk     (clk),
            .reset_n (reset_n),
            .sync_in (sync2[i]),
            .deb_out (deb[i])
        );
    end

    always_comb begin
        edge_vec = '0;
        for (int i = 0; i < WIDTH; i++) begin
            edge_vec[i] = edge_hit(EDGE_MODE, deb[i], deb_dly[i]);
        end
    end

    assign wr_en   = bus.chipselect && bus.write;
    assign clr_vec = (wr_en && bus.address == ADDR_EDGECAP) ? bus.writedata[WIDTH-1:0] : '0;

    // A fresh edge wins over a simultaneous clear so no event is lost
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            deb_dly <= '0;
            irqmask <= '0;
            edgecap <= '0;
        end else begin
            deb_dly <= deb;
            edgecap <= (edgecap & ~clr_vec) | edge_vec;
            if (wr_en && bus.address == ADDR_IRQMASK) irqmask <= bus.writedata[WIDTH-1:0];
        end
    end

    always_comb begin
        rd_next = '0;
        case (bus.address)
            ADDR_DATA:    rd_next = 32'(deb);
            ADDR_IRQMASK: rd_next = 32'(irqmask);
            ADDR_EDGECAP: rd_next = 32'(edgecap);
            default:      rd_next = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) bus.readdata <= '0;
        else          bus.readdata <= rd_next;
    end

    assign bus.irq = |(edgecap & irqmask);

endmodule

// File: tb/tb_alarm_sensor_pio.sv
// tb/tb_alarm_sensor_pio.sv - scoreboard bench for two alarm_sensor_pio configurations
module tb_alarm_sensor_pio;

    typedef struct {
        int          dut;
        logic [31:0] exp_rd;
        logic        exp_irq;
        string       name;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] in_port0 = 8'h00;
    logic [7:0] in_port1 = 8'h00;
    logic       samp_req = 1'b0;
    logic       samp_valid = 1'b0;
    int         n_checks = 0;
    int         n_pass = 0;
    exp_t       sb[$];

    alarm_sensor_pio_if bus0 ();
    alarm_sensor_pio_if bus1 ();

    alarm_sensor_pio #(.WIDTH(8), .DEBOUNCE_CYCLES(4), .EDGE_MODE(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .in_port(in_port0), .bus(bus0)
    );

    alarm_sensor_pio #(.WIDTH(8), .DEBOUNCE_CYCLES(0), .EDGE_MODE(2)) dut1 (
        .clk(clk), .reset_n(reset_n), .in_port(in_port1), .bus(bus1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Readdata is valid one edge after the request; compared on the following negedge
    always @(posedge clk) samp_valid <= samp_req;

    always @(negedge clk) begin
        if (samp_valid) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (e.dut == 0) begin
                    chk({e.name, "_rd"}, bus0.readdata, e.exp_rd);
                    chk({e.name, "_irq"}, 32'(bus0.irq), 32'(e.exp_irq));
                end else begin
                    chk({e.name, "_rd"}, bus1.readdata, e.exp_rd);
                    chk({e.name, "_irq"}, 32'(bus1.irq), 32'(e.exp_irq));
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rd(input int d, input logic [1:0] a, input logic [31:0] exp_rd,
                      input logic exp_irq, input string name);
        exp_t e;
        e.dut = d; e.exp_rd = exp_rd; e.exp_irq = exp_irq; e.name = name;
        if (d == 0) bus0.address = a;
        else        bus1.address = a;
        sb.push_back(e);
        samp_req = 1'b1;
        @(negedge clk);
        samp_req = 1'b0;
    endtask

    task automatic wr(input int d, input logic [1:0] a, input logic [31:0] data);
        if (d == 0) begin
            bus0.address = a; bus0.writedata = data; bus0.chipselect = 1'b1; bus0.write = 1'b1;
        end else begin
            bus1.address = a; bus1.writedata = data; bus1.chipselect = 1'b1; bus1.write = 1'b1;
        end
        @(negedge clk);
        if (d == 0) begin bus0.chipselect = 1'b0; bus0.write = 1'b0; end
        else        begin bus1.chipselect = 1'b0; bus1.write = 1'b0; end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus0.address = 2'd0; bus0.chipselect = 1'b0; bus0.write = 1'b0; bus0.writedata = '0;
        bus1.address = 2'd0; bus1.chipselect = 1'b0; bus1.write = 1'b0; bus1.writedata = '0;
        idle(3);
        reset_n = 1'b1;

        rd(0, 2'd0, 32'h0, 1'b0, "rst_data");
        rd(0, 2'd2, 32'h0, 1'b0, "rst_mask");
        rd(0, 2'd3, 32'h0, 1'b0, "rst_ecap");

        // 0x00 -> 0x05: visible exactly 8 cycles after the change
        in_port0 = 8'h05;
        for (int j = 0; j < 10; j++) rd(0, 2'd0, (j >= 7) ? 32'h05 : 32'h00, 1'b0, "deb_lat");
        rd(0, 2'd3, 32'h05, 1'b0, "ecap_05");
        wr(0, 2'd3, 32'hFF);
        rd(0, 2'd3, 32'h00, 1'b0, "ecap_clr");

        // 3-cycle glitch on bit 7 must be rejected
        in_port0 = 8'h85;
        for (int j = 0; j < 3; j++) rd(0, 2'd0, 32'h05, 1'b0, "glitch_a");
        in_port0 = 8'h05;
        for (int j = 0; j < 10; j++) rd(0, 2'd0, 32'h05, 1'b0, "glitch_b");
        rd(0, 2'd3, 32'h00, 1'b0, "glitch_ecap");

        wr(0, 2'd2, 32'h01);
        rd(0, 2'd2, 32'h01, 1'b0, "mask_rd");
        rd(0, 2'd1, 32'h00, 1'b0, "rsvd");
        in_port0 = 8'h04;
        idle(10);
        rd(0, 2'd3, 32'h00, 1'b0, "fall_nocap");
        rd(0, 2'd0, 32'h04, 1'b0, "fall_data");
        in_port0 = 8'h05;
        idle(10);
        rd(0, 2'd3, 32'h01, 1'b1, "irq_set");
        wr(0, 2'd3, 32'h01);
        rd(0, 2'd3, 32'h00, 1'b0, "irq_clr");

        wr(0, 2'd2, 32'h00);
        in_port0 = 8'h01;
        idle(10);
        in_port0 = 8'h05;
        idle(10);
        rd(0, 2'd3, 32'h04, 1'b0, "mask_off");
        wr(0, 2'd3, 32'h04);
        rd(0, 2'd3, 32'h00, 1'b0, "ecap2_clr");
        in_port0 = 8'h01;
        idle(10);
        in_port0 = 8'h05;
        idle(7);
        wr(0, 2'd3, 32'h04);
        rd(0, 2'd3, 32'h04, 1'b0, "collide");

        in_port0 = 8'hFF;
        idle(10);
        wr(0, 2'd2, 32'hFF);
        rd(0, 2'd3, 32'hFE, 1'b1, "pre_rst_ecap");
        rd(0, 2'd0, 32'hFF, 1'b1, "pre_rst_data");
        idle(1);
        reset_n = 1'b0;
        #1;
        chk("async_rst_rd", bus0.readdata, 32'h0);
        chk("async_rst_irq", 32'(bus0.irq), 32'h0);
        idle(2);
        reset_n = 1'b1;
        for (int j = 0; j < 10; j++) rd(0, 2'd0, (j >= 7) ? 32'hFF : 32'h00, 1'b0, "rst_lat");
        idle(3);
        rd(0, 2'd3, 32'hFF, 1'b0, "rst_ecap_ff");

        // Second instance: no debounce, capture on any edge
        in_port1 = 8'h08;
        for (int j = 0; j < 6; j++) rd(1, 2'd0, (j >= 3) ? 32'h08 : 32'h00, 1'b0, "d0_lat");
        rd(1, 2'd3, 32'h08, 1'b0, "any_rise");
        wr(1, 2'd2, 32'h08);
        rd(1, 2'd2, 32'h08, 1'b1, "d0_mask");
        wr(1, 2'd3, 32'h08);
        rd(1, 2'd3, 32'h00, 1'b0, "any_clr");
        in_port1 = 8'h00;
        idle(6);
        rd(1, 2'd3, 32'h08, 1'b1, "any_fall");
        rd(1, 2'd0, 32'h00, 1'b1, "d0_data0");
        rd(1, 2'd1, 32'h00, 1'b1, "d0_rsvd");
        in_port1 = 8'h08;
        idle(6);
        wr(1, 2'd0, 32'h00);
        rd(1, 2'd0, 32'h08, 1'b1, "wr0_ign");
        wr(1, 2'd1, 32'hFF);
        rd(1, 2'd1, 32'h00, 1'b1, "wr1_ign");

        idle(3);
        chk("sb_drain", 32'(sb.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alarm_sensor_pio.md
ALARM_SENSOR_PIO -- requirements
Module: alarm_sensor_pio

Interface
REQ-001 Parameter WIDTH, default 8, number of input bits (legal 1..32).
REQ-002 Parameter DEBOUNCE_CYCLES, default 16, consecutive stable cycles required to accept a change (0 = debounce bypassed).
REQ-003 Parameter EDGE_MODE, default 0, edge-capture source: 0 rising, 1 falling, 2 any.
REQ-004 clk  input  1  system clock; all state is updated on the rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 address  input  2  Avalon-MM word address.
REQ-007 chipselect  input  1  slave select; qualifies write.
REQ-008 write  input  1  write strobe, active high.
REQ-009 writedata  input  32  write data.
REQ-010 in_port  input  WIDTH  asynchronous sensor/switch inputs.
REQ-011 readdata  output  32  registered read data.
REQ-012 irq  output  1  level interrupt, active high.

Function
REQ-013 Each in_port bit SHALL pass through a 2-flop synchroniser (reset 0) before any other use.
REQ-014 Per bit, debounced value SHALL take the synchronised value only after that value has differed from it for DEBOUNCE_CYCLES consecutive clocks; any return to equality SHALL reset the bit's counter to 0.
REQ-015 With DEBOUNCE_CYCLES=0, debounced value SHALL equal synchronised value (1 register stage).
REQ-016 Counter width SHALL be clog2(DEBOUNCE_CYCLES+1) and SHALL saturate; no wrap-around.
REQ-017 Register map: 0 data (debounced, RO), 1 reserved (reads 0), 2 irqmask (RW), 3 edgecapture (W1C).
REQ-018 readdata SHALL be reloaded every clock with the register at address, zero-extended above WIDTH; read latency 1 cycle; no read strobe.
REQ-019 Writes SHALL occur when chipselect=1 and write=1; writes to addresses 0 and 1 SHALL be ignored.
REQ-020 Write to address 2 SHALL load irqmask from writedata[WIDTH-1:0].
REQ-021 An edgecapture bit SHALL set on the edge of its debounced bit selected by EDGE_MODE (debounced value compared with its own 1-cycle-delayed copy).
REQ-022 Write to address 3 SHALL clear each edgecapture bit whose writedata bit is 1.
REQ-023 Edge and clear on the same bit in the same cycle: bit SHALL remain set.
REQ-024 irq SHALL be OR-reduction of (edgecapture AND irqmask), driven from registers only (no in_port combinational path).
REQ-025 Total latency in_port change to readdata at address 0: 2 + DEBOUNCE_CYCLES + 1 + 1 cycles (sync, debounce, debounced register, readdata).

Reset
REQ-026 reset_n low SHALL asynchronously clear synchronisers, debounce counters, debounced values, delayed copies, irqmask, edgecapture and readdata to 0; irq SHALL read 0.
REQ-027 Input levels present at reset release SHALL not produce edge captures for bits whose value is 0; bits released at 1 SHALL capture a rising edge only after debounce completes.

Structure
REQ-028 Package alarm_pio_pkg SHALL hold register address constants (ADDR_DATA, ADDR_RSVD, ADDR_IRQMASK, ADDR_EDGECAP) and the EDGE_MODE encodings (EDGE_RISE, EDGE_FALL, EDGE_ANY).
REQ-029 One sub-module alarm_debounce (1 bit, parameter DEBOUNCE_CYCLES) SHALL be instantiated WIDTH times via generate; synchroniser, edge detect and register file stay in the top.

Verification (WIDTH=8, DEBOUNCE_CYCLES=4, EDGE_MODE=0 unless stated)
REQ-030 Reset: assert reset_n=0 mid-run with in_port=0xFF -> readdata=0, irq=0 immediately; after release, address 0 reads 0xFF after 8 cycles.
REQ-031 Debounce: in_port 0x00->0x05 held -> address 0 reads 0x05 exactly 8 cycles later; a 3-cycle pulse 0x80 -> data never shows bit 7.
REQ-032 IRQ: write irqmask=0x01, bit0 rises -> edgecapture=0x01, irq=1; write 0x01 to address 3 -> edgecapture=0x00, irq=0 next cycle.
REQ-033 Masking/collision: irqmask=0x00 with bit2 edge -> edgecapture=0x04, irq=0; W1C of 0x04 on the cycle bit2 sets again -> edgecapture stays 0x04.
REQ-034 Modes: EDGE_MODE=2, DEBOUNCE_CYCLES=0, bit3 toggles 0->1->0 -> edgecapture bit3 set on both edges; address 1 always reads 0; write to address 0 leaves data unchanged.
